nibble_word_packer: RTL and testbench

- Upstream stage of the 4-bit lane splitter/AND-gate sub-block.
- Accepts a stream of 4-bit nibbles over a valid/ready handshake and packs NIBS consecutive nibbles into one 128-bit word. Nibble k lands at bits [4k+3:4k]; the rest of the word is zero.
- Presents each completed word on a registered valid/ready output that drives the 128-bit input bus of the splitter stage.
- An early-terminate flag flushes a partially filled word.

---
 rtl/nibble_word_packer.sv | 75 +++++++
 tb/tb_nibble_word_packer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_word_packer.sv
// nibble_word_packer
// Packs NIBS consecutive 4-bit nibbles into one zero-extended W-bit word.
// Nibble k of a word lands at bits [4k+3:4k]. An in_last flag flushes a
// partially filled word early. The completed word is held in registered
// output storage until downstream takes it over a valid/ready handshake.

module nibble_word_packer #(
    parameter int NIBS = 3,
    parameter int W    = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_nib,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_word,
    output logic [5:0]   out_count
);

    // The nibble counter needs at least one bit, even when NIBS is 1
    localparam int CW = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBS - 1);

    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          transfer;
    logic          completing;
    logic [W-1:0]  nib_word;
    logic [W-1:0]  next_word;

    // The output register can take a new word when it is empty or is being
    // emptied this very cycle, which lets words flow back-to-back.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign transfer   = out_valid && out_ready;
    assign completing = (cnt == LAST_CNT) || in_last;

    // Slots above cnt are always zero in acc, so OR-ing in the new nibble
    // gives the word as it stands after this nibble is added.
    assign nib_word  = W'(in_nib) << {cnt, 2'b00};
    assign next_word = acc | nib_word;

    // Accumulate nibbles and move a finished word into the output register;
    // a completing accept overrides the clearing caused by a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_count <= '0;
        end else begin
            if (transfer) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (completing) begin
                    out_word  <= next_word;
                    out_count <= 6'(cnt) + 6'd1;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= next_word;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_word_packer.sv
// tb_nibble_word_packer
// Directed bench for nibble_word_packer. Two instances are exercised: the
// default NIBS=3 one and a full-width NIBS=32 one. Expected words are pushed
// into a per-instance queue as stimulus is issued; a monitor per instance
// pops and compares whenever a word is handed downstream.

module tb_nibble_word_packer;

    typedef struct packed {
        logic [127:0] w;
        logic [5:0]   c;
    } exp_t;

    logic         clk;
    logic         rst_n;

    logic         in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a;
    logic [3:0]   in_nib_a;
    logic [127:0] out_word_a;
    logic [5:0]   out_count_a;

    logic         in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b;
    logic [3:0]   in_nib_b;
    logic [127:0] out_word_b;
    logic [5:0]   out_count_b;

    exp_t qa[$];
    exp_t qb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    nibble_word_packer #(.NIBS(3), .W(128)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_nib    (in_nib_a),
        .in_last   (in_last_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_word  (out_word_a),
        .out_count (out_count_a)
    );

    nibble_word_packer #(.NIBS(32), .W(128)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_nib    (in_nib_b),
        .in_last   (in_last_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_word  (out_word_b),
        .out_count (out_count_b)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for throughput measurements
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one nibble to the chosen instance and hold it until accepted.
    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic applyStimulus(input int sel, input logic [3:0] nib,
                                 input logic last, output int waits);
        bit   done;
        logic rdy;
        waits = 0;
        done  = 1'b0;
        if (sel == 0) begin
            in_valid_a = 1'b1; in_nib_a = nib; in_last_a = last;
        end else begin
            in_valid_b = 1'b1; in_nib_b = nib; in_last_b = last;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? in_ready_a : in_ready_b;
            if (rdy) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
            waits++;
        end
        if (sel == 0) begin
            in_valid_a = 1'b0; in_last_a = 1'b0;
        end else begin
            in_valid_b = 1'b0; in_last_b = 1'b0;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: nibble %h never accepted", nib);
        end
    endtask

    // Monitor for the NIBS=3 instance: every handed-off word must match
    // the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) begin
                checkOutput("a_unexpected_word", out_word_a, 128'hx);
            end else begin
                exp_t e;
                e = qa.pop_front();
                checkOutput("a_word", out_word_a, e.w);
                checkOutput("a_count", 128'(out_count_a), 128'(e.c));
            end
        end
    end

    // Monitor for the NIBS=32 instance
    always @(negedge clk) begin
        if (rst_n && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) begin
                checkOutput("b_unexpected_word", out_word_b, 128'hx);
            end else begin
                exp_t e;
                e = qb.pop_front();
                checkOutput("b_word", out_word_b, e.w);
                checkOutput("b_count", 128'(out_count_b), 128'(e.c));
            end
        end
    end

    initial begin
        int w;
        int wsum;
        int t0;

        rst_n = 1'b0;
        in_valid_a = 1'b0; in_nib_a = 4'h0; in_last_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_nib_b = 4'h0; in_last_b = 1'b0; out_ready_b = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 128'(out_valid_a), 128'd0);
        checkOutput("rst_out_word", out_word_a, 128'd0);
        checkOutput("rst_out_count", 128'(out_count_a), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 128'(in_ready_a), 128'd1);
        @(posedge clk);
        #1;

        // A, B, C back-to-back with downstream ready
        $display("[TB] full word 0xA 0xB 0xC");
        qa.push_back('{w: 128'hCBA, c: 6'd3});
        wsum = 0;
        applyStimulus(0, 4'hA, 1'b0, w); wsum += w;
        applyStimulus(0, 4'hB, 1'b0, w); wsum += w;
        applyStimulus(0, 4'hC, 1'b0, w); wsum += w;
        checkOutput("abc_no_stall", 128'(wsum), 128'd0);
        @(negedge clk);
        checkOutput("abc_latency_valid", 128'(out_valid_a), 128'd1);
        @(posedge clk);
        #1;

        // Downstream stalled: first word held, later nibbles stall
        $display("[TB] backpressure 1..6");
        out_ready_a = 1'b0;
        qa.push_back('{w: 128'h321, c: 6'd3});
        qa.push_back('{w: 128'h654, c: 6'd3});
        applyStimulus(0, 4'h1, 1'b0, w);
        applyStimulus(0, 4'h2, 1'b0, w);
        applyStimulus(0, 4'h3, 1'b0, w);
        fork
            begin
                applyStimulus(0, 4'h4, 1'b0, w);
                applyStimulus(0, 4'h5, 1'b0, w);
                applyStimulus(0, 4'h6, 1'b0, w);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 128'(in_ready_a), 128'd0);
                    checkOutput("stall_hold_word", out_word_a, 128'h321);
                    checkOutput("stall_hold_count", 128'(out_count_a), 128'd3);
                end
                @(posedge clk);
                #1;
                out_ready_a = 1'b1;
            end
        join
        @(posedge clk);
        #1;

        // Early termination and a redundant in_last on the final slot
        $display("[TB] in_last short words");
        qa.push_back('{w: 128'h7, c: 6'd1});
        qa.push_back('{w: 128'h21, c: 6'd2});
        qa.push_back('{w: 128'h654, c: 6'd3});
        applyStimulus(0, 4'h7, 1'b1, w);
        applyStimulus(0, 4'h1, 1'b0, w);
        applyStimulus(0, 4'h2, 1'b1, w);
        applyStimulus(0, 4'h4, 1'b0, w);
        applyStimulus(0, 4'h5, 1'b0, w);
        applyStimulus(0, 4'h6, 1'b1, w);
        @(posedge clk);
        #1;

        // Continuous stream 0..8: nine accepts in nine cycles
        $display("[TB] continuous stream 0..8");
        qa.push_back('{w: 128'h210, c: 6'd3});
        qa.push_back('{w: 128'h543, c: 6'd3});
        qa.push_back('{w: 128'h876, c: 6'd3});
        wsum = 0;
        t0 = cycle;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 4'(i), 1'b0, w);
            wsum += w;
        end
        checkOutput("stream_cycles", 128'(cycle - t0), 128'd9);
        checkOutput("stream_no_stall", 128'(wsum), 128'd0);
        @(posedge clk);
        #1;

        // Reset with a pending word, then with a partial word
        $display("[TB] asynchronous reset");
        out_ready_a = 1'b0;
        applyStimulus(0, 4'h9, 1'b1, w);
        @(negedge clk);
        checkOutput("pending_valid", 128'(out_valid_a), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 128'(out_valid_a), 128'd0);
        checkOutput("async_rst_word", out_word_a, 128'd0);
        checkOutput("async_rst_count", 128'(out_count_a), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready_a = 1'b1;
        applyStimulus(0, 4'hE, 1'b0, w);
        applyStimulus(0, 4'hF, 1'b0, w);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.push_back('{w: 128'h321, c: 6'd3});
        applyStimulus(0, 4'h1, 1'b0, w);
        applyStimulus(0, 4'h2, 1'b0, w);
        applyStimulus(0, 4'h3, 1'b0, w);
        @(posedge clk);
        #1;

        // Full-width instance: 32 nibbles fill all 128 bits, count is 32
        $display("[TB] NIBS=32 full word");
        qb.push_back('{w: 128'hFEDCBA9876543210FEDCBA9876543210, c: 6'd32});
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1, 4'(i % 16), 1'b0, w);
        end
        repeat (4) @(posedge clk);
        #1;

        checkOutput("a_queue_drained", 128'(qa.size()), 128'd0);
        checkOutput("b_queue_drained", 128'(qb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
